// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave countdown timer.
package timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The single winning event for one edge after priority resolution.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_RECOVER,
        ACT_CLEAR,
        ACT_PAUSE,
        ACT_QUICK,
        ACT_RESUME,
        ACT_TICK,
        ACT_KEY
    } action_t;

    function automatic logic is_digit(input logic [BCD_W-1:0] d);
        return d <= BCD_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/timer_digit.sv
// One BCD down-counter digit with load and borrow chaining; wraps 0 -> MAX.
module timer_digit
    import timer_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] data,
    input  logic             dec_en,
    output logic [BCD_W-1:0] value,
    output logic             is_zero,
    output logic             borrow_out
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= data;
        end else if (dec_en) begin
            value <= is_zero ? BCD_W'(MAX) : value - BCD_W'(1);
        end
    end

    assign is_zero    = (value == '0);
    assign borrow_out = dec_en & is_zero;

endmodule

// File: rtl/timer_ctrl.sv
// Microwave timer sequencer: keypad entry, run/pause/clear FSM, MM:SS countdown.
// Define TIMER_BEEP_EN to enable the completion beep; otherwise beep is tied low.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int QS_SEC_TENS = 3,
    parameter int BEEP_TICKS  = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_data,
    input  logic             start,
    input  logic             stop_clear,
    input  logic             door_closed,
    input  logic             tick,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [2:0]       state,
    output logic             mag_on,
    output logic             done,
    output logic             beep
);

    state_t  state_q;
    state_t  state_d;
    action_t act;

    logic mt_zero, mo_zero, st_zero, so_zero;
    logic time_zero, time_one;

    logic             digit_load;
    logic [BCD_W-1:0] mt_data, mo_data, st_data, so_data;
    logic             so_dec, st_dec, mo_dec, mt_dec;
    logic             unused_borrow;

    assign time_zero = mt_zero & mo_zero & st_zero & so_zero;
    assign time_one  = mt_zero & mo_zero & st_zero & (sec_ones == BCD_W'(1));

    // Priority resolution: a command that has no effect in the current state
    // does not consume the edge, so a lower-priority event may still act.
    always_comb begin
        act = ACT_NONE;
        if (state_q > DONE) begin
            act = ACT_RECOVER;
        end else if (stop_clear && state_q == RUN) begin
            act = ACT_PAUSE;
        end else if (stop_clear && state_q != IDLE) begin
            act = ACT_CLEAR;
        end else if (!door_closed && state_q == RUN) begin
            act = ACT_PAUSE;
        end else if (start && door_closed && state_q == IDLE) begin
            act = ACT_QUICK;
        end else if (start && door_closed && (state_q inside {ENTRY, PAUSE}) && !time_zero) begin
            act = ACT_RESUME;
        end else if (tick && state_q == RUN && !time_zero) begin
            act = ACT_TICK;
        end else if (key_valid && is_digit(key_data) && (state_q inside {IDLE, ENTRY})
                     && sec_ones <= BCD_W'(SEC_TENS_MAX)) begin
            act = ACT_KEY;
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (act)
            ACT_RECOVER,
            ACT_CLEAR:  state_d = IDLE;
            ACT_PAUSE:  state_d = PAUSE;
            ACT_QUICK,
            ACT_RESUME: state_d = RUN;
            ACT_TICK:   if (time_one) state_d = DONE;
            ACT_KEY:    state_d = ENTRY;
            default:    state_d = state_q;
        endcase
    end

    always_comb begin
        digit_load = 1'b0;
        mt_data    = '0;
        mo_data    = '0;
        st_data    = '0;
        so_data    = '0;
        case (act)
            ACT_CLEAR: digit_load = 1'b1;
            ACT_QUICK: begin
                digit_load = 1'b1;
                st_data    = BCD_W'(QS_SEC_TENS);
            end
            ACT_KEY: begin
                digit_load = 1'b1;
                mt_data    = min_ones;
                mo_data    = sec_tens;
                st_data    = sec_ones;
                so_data    = key_data;
            end
            default: digit_load = 1'b0;
        endcase
    end

    assign so_dec = (act == ACT_TICK);

    timer_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .clr(clr), .load(digit_load), .data(so_data), .dec_en(so_dec),
        .value(sec_ones), .is_zero(so_zero), .borrow_out(st_dec)
    );

    timer_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .clr(clr), .load(digit_load), .data(st_data), .dec_en(st_dec),
        .value(sec_tens), .is_zero(st_zero), .borrow_out(mo_dec)
    );

    timer_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .clr(clr), .load(digit_load), .data(mo_data), .dec_en(mo_dec),
        .value(min_ones), .is_zero(mo_zero), .borrow_out(mt_dec)
    );

    // Ticks are suppressed at 00:00, so the top digit never borrows out.
    timer_digit #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk(clk), .clr(clr), .load(digit_load), .data(mt_data), .dec_en(mt_dec),
        .value(min_tens), .is_zero(mt_zero), .borrow_out(unused_borrow)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            mag_on  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_on  <= (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    assign state = state_q;

`ifdef TIMER_BEEP_EN
    localparam int BEEP_W = ($clog2(BEEP_TICKS + 1) < 2) ? 2 : $clog2(BEEP_TICKS + 1);

    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (clr || state_d != DONE) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_q != DONE) begin
            beep     <= 1'b1;
            beep_cnt <= '0;
        end else if (beep && tick) begin
            if (beep_cnt == BEEP_W'(BEEP_TICKS - 1)) beep <= 1'b0;
            beep_cnt <= beep_cnt + BEEP_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^BEEP_TICKS;
    assign beep       = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios then random traffic,
// all compared against a seconds-based behavioural model.
module tb_timer_ctrl;

    localparam int QS = 3;
    localparam int BT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       clr, key_valid, start, stop_clear, door_closed, tick;
    logic [3:0] key_data;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;
    logic       mag_on, done, beep;

    timer_ctrl #(.QS_SEC_TENS(QS), .BEEP_TICKS(BT)) dut (
        .clk(clk), .clr(clr), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop_clear(stop_clear), .door_closed(door_closed), .tick(tick),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .state(state), .mag_on(mag_on), .done(done), .beep(beep)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: time kept as plain digits, decremented through total seconds.
    int md[4];
    int ms;
    bit mmag, mdone, mbeep;
    int mbcnt;

    function automatic int secs_of();
        return (md[0] * 10 + md[1]) * 60 + md[2] * 10 + md[3];
    endfunction

    task automatic set_secs(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        md[0] = mm / 10; md[1] = mm % 10;
        md[2] = ss / 10; md[3] = ss % 10;
    endtask

    task automatic model_step();
        int prev;
        int secs;
        prev = ms;
        secs = secs_of();
        if (clr) begin
            md = '{0, 0, 0, 0};
            ms = M_IDLE;
            mbeep = 0;
            mbcnt = 0;
        end else begin
            if (stop_clear && ms != M_IDLE) begin
                if (ms == M_RUN) ms = M_PAUSE;
                else begin ms = M_IDLE; md = '{0, 0, 0, 0}; end
            end else if (!door_closed && ms == M_RUN) begin
                ms = M_PAUSE;
            end else if (start && door_closed && ms == M_IDLE) begin
                md = '{0, 0, QS, 0};
                ms = M_RUN;
            end else if (start && door_closed && (ms == M_ENTRY || ms == M_PAUSE) && secs != 0) begin
                ms = M_RUN;
            end else if (tick && ms == M_RUN && secs > 0) begin
                set_secs(secs - 1);
                if (secs == 1) ms = M_DONE;
            end else if (key_valid && key_data <= 9 && (ms == M_IDLE || ms == M_ENTRY) && md[3] <= 5) begin
                md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = int'(key_data);
                ms = M_ENTRY;
            end
`ifdef TIMER_BEEP_EN
            if (ms != M_DONE) mbeep = 0;
            else if (prev != M_DONE) begin mbeep = 1; mbcnt = 0; end
            else if (mbeep && tick) begin
                mbcnt++;
                if (mbcnt == BT) mbeep = 0;
            end
`else
            mbeep = 0;
`endif
        end
        mmag  = (ms == M_RUN);
        mdone = (ms == M_DONE);
    endtask

    function automatic logic [15:0] dut_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check_all();
        logic [15:0] e;
        e = {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
        check("model_time", dut_time(), e);
        check("model_state", 16'(state), 16'(ms));
        check("model_mag_on", 16'(mag_on), 16'(mmag));
        check("model_done", 16'(done), 16'(mdone));
        check("model_beep", 16'(beep), 16'(mbeep));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        clr = 0; key_valid = 0; start = 0; stop_clear = 0; tick = 0;
    endtask

    task automatic press(input int k);
        key_valid = 1; key_data = 4'(k); cycle();
    endtask
    task automatic push_start(); start = 1;      cycle(); endtask
    task automatic push_stop();  stop_clear = 1; cycle(); endtask
    task automatic pulse_tick(); tick = 1;       cycle(); endtask

    initial begin
        clr = 1; key_valid = 0; key_data = 0; start = 0; stop_clear = 0;
        door_closed = 1; tick = 0;
        md = '{0, 0, 0, 0}; ms = M_IDLE; mmag = 0; mdone = 0; mbeep = 0; mbcnt = 0;

        cycle();
        check("rst_time", dut_time(), 16'h0000);
        check("rst_state", 16'(state), 16'd0);
        check("rst_outputs", {13'd0, mag_on, done, beep}, 16'd0);

        // Key entry and the sec_tens guard.
        press(1); press(2); press(3);
        check("entry_0123", dut_time(), 16'h0123);
        check("entry_state", 16'(state), 16'd1);
        press(7);
        check("entry_1237", dut_time(), 16'h1237);
        press(8);
        check("entry_guard", dut_time(), 16'h1237);

        // Full countdown from 01:00 to DONE.
        push_stop();
        press(12);
        check("key_gt9_ignored", 16'(state), 16'd0);
        press(1); press(0); press(0);
        check("entry_0100", dut_time(), 16'h0100);
        push_start();
        check("run_state", 16'(state), 16'd2);
        check("run_mag", 16'(mag_on), 16'd1);
        pulse_tick();
        check("borrow_0059", dut_time(), 16'h0059);
        repeat (58) pulse_tick();
        check("count_0001", dut_time(), 16'h0001);
        pulse_tick();
        check("done_time", dut_time(), 16'h0000);
        check("done_state", 16'(state), 16'd4);
        check("done_flags", {14'd0, mag_on, done}, 16'b01);
`ifdef TIMER_BEEP_EN
        check("beep_rise", 16'(beep), 16'd1);
        pulse_tick(); pulse_tick();
        check("beep_hold", 16'(beep), 16'd1);
        pulse_tick();
        check("beep_fall", 16'(beep), 16'd0);
`else
        check("beep_off", 16'(beep), 16'd0);
`endif
        pulse_tick();
        check("done_held", {dut_time(), 16'h0}, {16'h0000, 16'h0});
        check("done_held_flag", 16'(done), 16'd1);
        push_stop();
        check("done_clear", {13'd0, state, 16'h0} >> 16, 16'd0);
        check("done_clear_flag", 16'(done), 16'd0);

        // Quick start to DONE, then stop during the beep.
        push_start();
        check("quick_time", dut_time(), 16'h0030);
        repeat (30) pulse_tick();
        check("quick_done", 16'(state), 16'd4);
        pulse_tick();
        push_stop();
        check("beep_stop", 16'(beep), 16'd0);
        check("beep_stop_state", 16'(state), 16'd0);

        // Door opened together with a tick pauses without counting.
        push_start();
        door_closed = 0; tick = 1; cycle();
        check("door_pause", 16'(state), 16'd3);
        check("door_time", dut_time(), 16'h0030);
        check("door_mag", 16'(mag_on), 16'd0);
        door_closed = 1;
        push_start();
        check("resume", 16'(state), 16'd2);
        check("resume_time", dut_time(), 16'h0030);

        // Minute borrow, stop -> pause -> clear, start with door open.
        push_stop(); push_stop();
        press(1); press(0); press(0); press(0);
        check("entry_1000", dut_time(), 16'h1000);
        push_start(); pulse_tick();
        check("borrow_0959", dut_time(), 16'h0959);
        push_stop();
        check("stop_pause", 16'(state), 16'd3);
        push_stop();
        check("stop_clear", dut_time(), 16'h0000);
        door_closed = 0;
        push_start();
        check("open_start", 16'(state), 16'd0);
        door_closed = 1;

        // Start on 00:00 in ENTRY is ignored.
        press(0);
        push_start();
        check("zero_start", 16'(state), 16'd1);
        push_stop();

        // clr mid-run.
        press(4); press(5); push_start();
        clr = 1; cycle();
        check("clr_time", dut_time(), 16'h0000);
        check("clr_state", {13'd0, state}, 16'd0);
        check("clr_flags", {14'd0, mag_on, done}, 16'd0);

        // Random traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            int r;
            if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
            clr  = ($urandom_range(0, 599) == 0);
            tick = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 63);
            if (r < 4) start = 1;
            else if (r == 4) stop_clear = 1;
            else if (r < 13 && door_closed) begin
                key_valid = 1;
                key_data  = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
